// File: rtl/dcache_miss_requester.sv
// D$ miss requester: optional writeback store, then a line fill load, then a fill pulse back to the D$.
// Define DCACHE_MISS_TIMEOUT_EN to add a response watchdog of TIMEOUT_CYCLES cycles.
module dcache_miss_requester #(
  parameter int LINE_WIDTH     = 128,
  parameter int ADDR_WIDTH     = 32,
  parameter int THR_WIDTH      = 2,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  miss_valid,
  output logic                  miss_ready,
  input  logic [ADDR_WIDTH-1:0] miss_addr,
  input  logic [THR_WIDTH-1:0]  miss_thread_id,
  input  logic                  miss_wb_needed,
  input  logic [ADDR_WIDTH-1:0] miss_wb_addr,
  input  logic [LINE_WIDTH-1:0] miss_wb_data,
  output logic                  req_valid,
  output logic [ADDR_WIDTH-1:0] req_addr,
  output logic                  req_is_store,
  output logic [LINE_WIDTH-1:0] req_data,
  output logic [THR_WIDTH-1:0]  req_thread_id,
  input  logic                  rsp_valid_miss,
  input  logic                  rsp_cache_id,
  input  logic                  rsp_bus_error,
  input  logic [LINE_WIDTH-1:0] rsp_data_miss,
  output logic                  fill_valid,
  output logic [LINE_WIDTH-1:0] fill_data,
  output logic [THR_WIDTH-1:0]  fill_thread_id,
  output logic                  fill_bus_error
);

  typedef enum logic [2:0] {
    IDLE, WB_REQ, WB_WAIT, FILL_REQ, FILL_WAIT, DONE
  } state_t;

  state_t                r_state, w_state_next;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [THR_WIDTH-1:0]  r_thr;
  logic [LINE_WIDTH-1:0] r_data;
  logic                  r_err;
  logic [ADDR_WIDTH-1:0] r_req_addr;
  logic                  r_req_is_store;
  logic [LINE_WIDTH-1:0] r_req_data;
  logic [THR_WIDTH-1:0]  r_req_thr;

  logic w_accept, w_rsp_d, w_waiting, w_timeout;

  assign w_accept  = miss_valid & (r_state == IDLE);
  assign w_rsp_d   = rsp_valid_miss & rsp_cache_id;
  assign w_waiting = (r_state == WB_WAIT) | (r_state == FILL_WAIT);

`ifdef DCACHE_MISS_TIMEOUT_EN
  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  logic [TW-1:0] r_tmo_cnt;

  assign w_timeout = w_waiting & (r_tmo_cnt == TW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clock) begin
    if (reset || (w_state_next != r_state) || !w_waiting) r_tmo_cnt <= '0;
    else                                                  r_tmo_cnt <= r_tmo_cnt + 1'b1;
  end
`else
  assign w_timeout = 1'b0;
`endif

  always_ff @(posedge clock) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_state_next;
  end

  // A same-cycle D$ response always takes precedence over the watchdog.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:      if (w_accept) w_state_next = miss_wb_needed ? WB_REQ : FILL_REQ;
      WB_REQ:    w_state_next = WB_WAIT;
      WB_WAIT:   if (w_rsp_d)        w_state_next = rsp_bus_error ? DONE : FILL_REQ;
                 else if (w_timeout) w_state_next = DONE;
      FILL_REQ:  w_state_next = FILL_WAIT;
      FILL_WAIT: if (w_rsp_d || w_timeout) w_state_next = DONE;
      DONE:      w_state_next = IDLE;
      default:   w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_addr         <= '0;
      r_thr          <= '0;
      r_data         <= '0;
      r_err          <= 1'b0;
      r_req_addr     <= '0;
      r_req_is_store <= 1'b0;
      r_req_data     <= '0;
      r_req_thr      <= '0;
    end else begin
      if (w_accept) begin
        r_addr <= miss_addr;
        r_thr  <= miss_thread_id;
        r_data <= '0;
        r_err  <= 1'b0;
      end
      // Request fields are loaded on entry to a request state and then held.
      if (r_state == IDLE && w_accept && miss_wb_needed) begin
        r_req_addr     <= miss_wb_addr;
        r_req_is_store <= 1'b1;
        r_req_data     <= miss_wb_data;
        r_req_thr      <= miss_thread_id;
      end else if (w_state_next == FILL_REQ && r_state != FILL_REQ) begin
        r_req_addr     <= (r_state == IDLE) ? miss_addr : r_addr;
        r_req_is_store <= 1'b0;
        r_req_data     <= '0;
        r_req_thr      <= (r_state == IDLE) ? miss_thread_id : r_thr;
      end
      if (r_state == WB_WAIT) begin
        if (w_rsp_d)        r_err <= rsp_bus_error;
        else if (w_timeout) r_err <= 1'b1;
      end
      if (r_state == FILL_WAIT) begin
        if (w_rsp_d) begin
          r_data <= rsp_data_miss;
          r_err  <= rsp_bus_error;
        end else if (w_timeout) begin
          r_err  <= 1'b1;
        end
      end
    end
  end

  assign miss_ready     = (r_state == IDLE);
  assign req_valid      = (r_state == WB_REQ) | (r_state == FILL_REQ);
  assign req_addr       = r_req_addr;
  assign req_is_store   = r_req_is_store;
  assign req_data       = r_req_data;
  assign req_thread_id  = r_req_thr;
  assign fill_valid     = (r_state == DONE);
  assign fill_data      = (r_state == DONE && !r_err) ? r_data : '0;
  assign fill_thread_id = (r_state == DONE) ? r_thr : '0;
  assign fill_bus_error = (r_state == DONE) & r_err;

endmodule

// File: tb/tb_dcache_miss_requester.sv
// Directed testbench for dcache_miss_requester; define DCACHE_MISS_TIMEOUT_EN to include the watchdog test.
module tb_dcache_miss_requester;
  localparam int LW = 128;
  localparam int AW = 32;
  localparam int TW = 2;

  logic          clock = 1'b0;
  logic          reset;
  logic          miss_valid, miss_ready, miss_wb_needed;
  logic [AW-1:0] miss_addr, miss_wb_addr;
  logic [TW-1:0] miss_thread_id;
  logic [LW-1:0] miss_wb_data;
  logic          req_valid, req_is_store;
  logic [AW-1:0] req_addr;
  logic [LW-1:0] req_data;
  logic [TW-1:0] req_thread_id;
  logic          rsp_valid_miss, rsp_cache_id, rsp_bus_error;
  logic [LW-1:0] rsp_data_miss;
  logic          fill_valid, fill_bus_error;
  logic [LW-1:0] fill_data;
  logic [TW-1:0] fill_thread_id;

  int n_vec = 0;
  int n_err = 0;
  int n_req = 0;
  int n_fill = 0;

  dcache_miss_requester #(
    .LINE_WIDTH(LW), .ADDR_WIDTH(AW), .THR_WIDTH(TW), .TIMEOUT_CYCLES(8)
  ) dut (
    .clock(clock), .reset(reset),
    .miss_valid(miss_valid), .miss_ready(miss_ready), .miss_addr(miss_addr),
    .miss_thread_id(miss_thread_id), .miss_wb_needed(miss_wb_needed),
    .miss_wb_addr(miss_wb_addr), .miss_wb_data(miss_wb_data),
    .req_valid(req_valid), .req_addr(req_addr), .req_is_store(req_is_store),
    .req_data(req_data), .req_thread_id(req_thread_id),
    .rsp_valid_miss(rsp_valid_miss), .rsp_cache_id(rsp_cache_id),
    .rsp_bus_error(rsp_bus_error), .rsp_data_miss(rsp_data_miss),
    .fill_valid(fill_valid), .fill_data(fill_data),
    .fill_thread_id(fill_thread_id), .fill_bus_error(fill_bus_error)
  );

  always #5 clock = ~clock;

  always @(negedge clock) begin
    if (req_valid)  n_req++;
    if (fill_valid) n_fill++;
  end

  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic start_miss(input logic [AW-1:0] a, input logic [TW-1:0] t, input logic wb,
                            input logic [AW-1:0] wa, input logic [LW-1:0] wd);
    miss_addr = a; miss_thread_id = t; miss_wb_needed = wb;
    miss_wb_addr = wa; miss_wb_data = wd; miss_valid = 1'b1;
    tick();
    miss_valid = 1'b0;
  endtask

  task automatic respond(input logic cid, input logic berr, input logic [LW-1:0] d);
    rsp_valid_miss = 1'b1; rsp_cache_id = cid; rsp_bus_error = berr; rsp_data_miss = d;
    tick();
    rsp_valid_miss = 1'b0; rsp_cache_id = 1'b0; rsp_bus_error = 1'b0; rsp_data_miss = '0;
  endtask

  task automatic test_reset();
    reset = 1'b1; miss_valid = 0; miss_addr = '0; miss_thread_id = '0; miss_wb_needed = 0;
    miss_wb_addr = '0; miss_wb_data = '0; rsp_valid_miss = 0; rsp_cache_id = 0;
    rsp_bus_error = 0; rsp_data_miss = '0;
    tick(2);
    reset = 1'b0;
    n_vec++; if (miss_ready !== 1'b1) begin n_err++; $display("FAIL reset_miss_ready: got %b want 1", miss_ready); end
    n_vec++; if ({req_valid, req_is_store, req_addr, req_data, req_thread_id} !== '0) begin
      n_err++; $display("FAIL reset_req_outputs: req_valid=%b addr=%h want all 0", req_valid, req_addr); end
    n_vec++; if ({fill_valid, fill_bus_error, fill_data, fill_thread_id} !== '0) begin
      n_err++; $display("FAIL reset_fill_outputs: fill_valid=%b data=%h want all 0", fill_valid, fill_data); end
    $display("test_reset done");
  endtask

  task automatic test_clean_miss();
    logic [LW-1:0] exp_d;
    exp_d = {16{8'hA5}};
    n_req = 0; n_fill = 0;
    start_miss(32'h100, 2'd2, 1'b0, '0, '0);
    n_vec++; if ({req_valid, req_is_store, req_addr, req_thread_id} !== {1'b1, 1'b0, 32'h100, 2'd2}) begin
      n_err++; $display("FAIL clean_req: got v=%b st=%b a=%h t=%0d want v=1 st=0 a=100 t=2",
                        req_valid, req_is_store, req_addr, req_thread_id); end
    n_vec++; if (miss_ready !== 1'b0) begin n_err++; $display("FAIL clean_busy: got miss_ready=%b want 0", miss_ready); end
    tick(5);
    respond(1'b1, 1'b0, exp_d);
    n_vec++; if ({fill_valid, fill_bus_error, fill_thread_id} !== {1'b1, 1'b0, 2'd2}) begin
      n_err++; $display("FAIL clean_fill: got v=%b e=%b t=%0d want v=1 e=0 t=2", fill_valid, fill_bus_error, fill_thread_id); end
    n_vec++; if (fill_data !== exp_d) begin n_err++; $display("FAIL clean_fill_data: got %h want %h", fill_data, exp_d); end
    tick();
    n_vec++; if ({fill_valid, miss_ready} !== 2'b01) begin
      n_err++; $display("FAIL clean_after: got fill_valid=%b miss_ready=%b want 0 1", fill_valid, miss_ready); end
    n_vec++; if (n_req != 1 || n_fill != 1) begin
      n_err++; $display("FAIL clean_counts: got req=%0d fill=%0d want 1 1", n_req, n_fill); end
    $display("test_clean_miss done");
  endtask

  task automatic test_dirty_miss();
    logic [LW-1:0] exp_d;
    exp_d = {8{16'h5A3C}};
    n_req = 0; n_fill = 0;
    start_miss(32'h80, 2'd1, 1'b1, 32'h40, 128'h1234);
    n_vec++; if ({req_valid, req_is_store, req_addr, req_thread_id} !== {1'b1, 1'b1, 32'h40, 2'd1}) begin
      n_err++; $display("FAIL dirty_store_req: got v=%b st=%b a=%h t=%0d want v=1 st=1 a=40 t=1",
                        req_valid, req_is_store, req_addr, req_thread_id); end
    n_vec++; if (req_data !== 128'h1234) begin n_err++; $display("FAIL dirty_store_data: got %h want 1234", req_data); end
    tick();
    n_vec++; if (req_valid !== 1'b0) begin n_err++; $display("FAIL dirty_no_b2b: got req_valid=%b want 0", req_valid); end
    tick(2);
    respond(1'b1, 1'b0, 128'hDEAD);
    n_vec++; if ({req_valid, req_is_store, req_addr, req_data} !== {1'b1, 1'b0, 32'h80, 128'h0}) begin
      n_err++; $display("FAIL dirty_load_req: got v=%b st=%b a=%h d=%h want v=1 st=0 a=80 d=0",
                        req_valid, req_is_store, req_addr, req_data); end
    n_vec++; if (fill_valid !== 1'b0) begin n_err++; $display("FAIL dirty_early_fill: got %b want 0", fill_valid); end
    tick(3);
    n_vec++; if (req_addr !== 32'h80) begin n_err++; $display("FAIL dirty_req_hold: got %h want 80", req_addr); end
    respond(1'b1, 1'b0, exp_d);
    n_vec++; if ({fill_valid, fill_bus_error, fill_thread_id, fill_data} !== {1'b1, 1'b0, 2'd1, exp_d}) begin
      n_err++; $display("FAIL dirty_fill: got v=%b e=%b t=%0d d=%h want v=1 e=0 t=1 d=%h",
                        fill_valid, fill_bus_error, fill_thread_id, fill_data, exp_d); end
    tick();
    n_vec++; if (n_req != 2 || n_fill != 1) begin
      n_err++; $display("FAIL dirty_counts: got req=%0d fill=%0d want 2 1", n_req, n_fill); end
    $display("test_dirty_miss done");
  endtask

  task automatic test_wb_bus_error();
    n_req = 0; n_fill = 0;
    start_miss(32'h300, 2'd3, 1'b1, 32'h140, {4{32'hCAFEF00D}});
    tick(2);
    respond(1'b1, 1'b1, {4{32'h77777777}});
    n_vec++; if (req_valid !== 1'b0) begin n_err++; $display("FAIL wberr_no_load: got req_valid=%b want 0", req_valid); end
    n_vec++; if ({fill_valid, fill_bus_error, fill_thread_id, fill_data} !== {1'b1, 1'b1, 2'd3, 128'h0}) begin
      n_err++; $display("FAIL wberr_fill: got v=%b e=%b t=%0d d=%h want v=1 e=1 t=3 d=0",
                        fill_valid, fill_bus_error, fill_thread_id, fill_data); end
    tick();
    n_vec++; if (miss_ready !== 1'b1) begin n_err++; $display("FAIL wberr_ready: got %b want 1", miss_ready); end
    n_vec++; if (n_req != 1 || n_fill != 1) begin
      n_err++; $display("FAIL wberr_counts: got req=%0d fill=%0d want 1 1", n_req, n_fill); end
    $display("test_wb_bus_error done");
  endtask

  task automatic test_icache_ignored();
    logic [LW-1:0] ones, exp_d;
    ones = '1;
    exp_d = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
    n_fill = 0;
    start_miss(32'h200, 2'd0, 1'b0, '0, '0);
    tick();
    respond(1'b0, 1'b0, ones);
    n_vec++; if (fill_valid !== 1'b0) begin n_err++; $display("FAIL icache_ignored: got fill_valid=%b want 0", fill_valid); end
    tick();
    respond(1'b1, 1'b0, exp_d);
    n_vec++; if ({fill_valid, fill_data} !== {1'b1, exp_d}) begin
      n_err++; $display("FAIL icache_dfill: got v=%b d=%h want v=1 d=%h", fill_valid, fill_data, exp_d); end
    tick();
    n_vec++; if (n_fill != 1) begin n_err++; $display("FAIL icache_counts: got fill=%0d want 1", n_fill); end
    $display("test_icache_ignored done");
  endtask

  task automatic test_reset_mid_op();
    n_fill = 0;
    start_miss(32'h480, 2'd2, 1'b0, '0, '0);
    tick(2);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    n_vec++; if (miss_ready !== 1'b1) begin n_err++; $display("FAIL midrst_ready: got %b want 1", miss_ready); end
    n_vec++; if ({req_valid, req_is_store, req_addr, req_data, req_thread_id,
                  fill_valid, fill_bus_error, fill_data, fill_thread_id} !== '0) begin
      n_err++; $display("FAIL midrst_outputs: req_addr=%h fill_valid=%b want all 0", req_addr, fill_valid); end
    respond(1'b1, 1'b0, {16{8'h3C}});
    tick(2);
    n_vec++; if (n_fill != 0 || miss_ready !== 1'b1) begin
      n_err++; $display("FAIL midrst_no_fill: got fill=%0d ready=%b want 0 1", n_fill, miss_ready); end
    $display("test_reset_mid_op done");
  endtask

`ifdef DCACHE_MISS_TIMEOUT_EN
  task automatic test_timeout();
    int first_fill;
    first_fill = -1;
    start_miss(32'h500, 2'd1, 1'b0, '0, '0);
    tick();
    for (int c = 1; c <= 10; c++) begin
      tick();
      if (fill_valid === 1'b1 && first_fill < 0) first_fill = c;
    end
    n_vec++; if (first_fill != 8) begin
      n_err++; $display("FAIL timeout_cycle: got fill at %0d want 8 cycles after FILL_WAIT entry", first_fill); end
    $display("test_timeout done");
  endtask

  task automatic test_timeout_err();
    start_miss(32'h540, 2'd3, 1'b0, '0, '0);
    tick(9);
    n_vec++; if ({fill_valid, fill_bus_error, fill_data} !== {1'b1, 1'b1, 128'h0}) begin
      n_err++; $display("FAIL timeout_fill: got v=%b e=%b d=%h want v=1 e=1 d=0", fill_valid, fill_bus_error, fill_data); end
    tick();
    $display("test_timeout_err done");
  endtask
`endif

  initial begin
    test_reset();
    test_clean_miss();
    test_dirty_miss();
    test_wb_bus_error();
    test_icache_ignored();
    test_reset_mid_op();
`ifdef DCACHE_MISS_TIMEOUT_EN
    test_timeout();
    test_timeout_err();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/dcache_miss_requester.md
Name: dcache_miss_requester

Overview:
- Core-side initiator for the D$ miss path to the memory hierarchy.
- Accepts one miss from the D$ at a time and, if the victim line is dirty, issues a writeback store first.
- Then issues the line fill load, waits for the memory-side response tagged for D$, and returns the line or a bus error to the D$.
- Drives the dcache_req_valid_miss / dcache_req_info_miss pair and consumes the shared rsp_* response bus.

Parameters:
- LINE_WIDTH, 128, bits per cache line (equals DCACHE_LINE_WIDTH).
- ADDR_WIDTH, 32, width of the line-index address sent to memory.
- THR_WIDTH, 2, width of the thread id (THR_PER_CORE_WIDTH).
- TIMEOUT_CYCLES, 1024, watchdog limit; used only with the optional feature.

Ports:
- clock  in  1  core clock; single clock domain.
- reset  in  1  synchronous, active-high reset.
- miss_valid  in  1  D$ presents a miss.
- miss_ready  out  1  high only in IDLE; a miss is accepted when miss_valid & miss_ready.
- miss_addr  in  ADDR_WIDTH  line address to fill.
- miss_thread_id  in  THR_WIDTH  requesting thread.
- miss_wb_needed  in  1  victim is dirty.
- miss_wb_addr  in  ADDR_WIDTH  victim line address.
- miss_wb_data  in  LINE_WIDTH  victim line data.
- req_valid  out  1  one-cycle request pulse to the memory hierarchy (dcache_req_valid_miss).
- req_addr  out  ADDR_WIDTH  request address.
- req_is_store  out  1  1 = writeback, 0 = fill.
- req_data  out  LINE_WIDTH  store data; zero on loads.
- req_thread_id  out  THR_WIDTH  thread id of the request.
- rsp_valid_miss  in  1  response valid.
- rsp_cache_id  in  1  0 = I$, 1 = D$.
- rsp_bus_error  in  1  response carries a bus error.
- rsp_data_miss  in  LINE_WIDTH  response line data.
- fill_valid  out  1  one-cycle pulse to the D$.
- fill_data  out  LINE_WIDTH  line returned to the D$.
- fill_thread_id  out  THR_WIDTH  thread the fill belongs to.
- fill_bus_error  out  1  miss terminated with a bus error.

Behaviour:
- Reset: state = IDLE. All outputs 0 except miss_ready = 1. Captured miss registers cleared.
- Reset has priority over every transition, including mid-operation: the in-flight request is abandoned, no fill_valid is produced, and any later response is ignored because the FSM is in IDLE.
- States: IDLE, WB_REQ, WB_WAIT, FILL_REQ, FILL_WAIT, DONE.
- IDLE: on miss_valid & miss_ready, register all miss_* inputs. Next state is WB_REQ if miss_wb_needed, else FILL_REQ.
- WB_REQ (1 cycle):
  - req_valid = 1, req_is_store = 1, req_addr = wb_addr, req_data = wb_data, req_thread_id = captured id.
  - Next state WB_WAIT.
- WB_WAIT: wait for rsp_valid_miss & rsp_cache_id == 1.
  - On bus error: set err, go to DONE; no fill is issued.
  - Otherwise go to FILL_REQ; rsp_data_miss is ignored.
- FILL_REQ (1 cycle):
  - req_valid = 1, req_is_store = 0, req_addr = captured miss_addr, req_data = 0.
  - Next state FILL_WAIT.
- FILL_WAIT: on rsp_valid_miss & rsp_cache_id == 1, latch rsp_data_miss into the data register and rsp_bus_error into err, then go to DONE.
- DONE (1 cycle):
  - fill_valid = 1, fill_data = data register (zero if err), fill_thread_id = captured id, fill_bus_error = err.
  - Next state IDLE.
- Latency:
  - Accept at cycle N → req_valid at N+1.
  - D$ response at cycle M → next request (WB case) or fill_valid at M+1.
  - Clean-miss minimum: accept N → fill_valid at mem_latency + 3.
- req_* fields hold their last value outside request cycles; only req_valid qualifies them.
- Responses with rsp_cache_id == 0 are ignored in every state.
- D$ responses arriving in IDLE, WB_REQ, FILL_REQ or DONE are ignored. The memory side never returns one response for two requests.
- miss_valid while miss_ready = 0 is not accepted. The D$ must hold the miss until it is accepted.
- Exactly one request is outstanding at any time. req_valid is never asserted in two consecutive cycles.

Optional Feature:
- Macro: DCACHE_MISS_TIMEOUT_EN.
- Enabled:
  - A counter runs in WB_WAIT and FILL_WAIT and is cleared on every state change.
  - When it reaches TIMEOUT_CYCLES-1 with no D$ response, go to DONE with err = 1; fill_valid is pulsed with fill_bus_error = 1.
  - A response arriving in that same cycle wins over the timeout.
- Disabled: no counter exists; the FSM waits indefinitely.

Test Plan:
- Clean miss: addr 0x100, thread 2, wb_needed 0; D$ response 5 cycles after the request with data 0xA5A5...A5 → exactly one req_valid pulse with is_store = 0, addr 0x100; fill_valid one cycle after the response with data 0xA5...A5, thread 2, bus_error 0.
- Dirty miss: wb addr 0x40, wb data 0x1234, fill addr 0x80 → a store pulse (addr 0x40, data 0x1234), then a load pulse (addr 0x80) in the cycle after the first response; a single fill_valid after the second response.
- Writeback bus error: rsp_bus_error = 1 on the WB response → no load request; fill_valid with fill_bus_error = 1 and fill_data = 0; miss_ready = 1 on the next cycle.
- I$ response (cache_id 0, data 0xFF..FF) during FILL_WAIT → ignored; the following D$ response completes the fill with the D$ data.
- Reset asserted in FILL_WAIT, then a D$ response → no fill_valid, miss_ready = 1, all outputs at their reset values.
- With DCACHE_MISS_TIMEOUT_EN and TIMEOUT_CYCLES = 8, no response → fill_valid with bus_error = 1 exactly 8 cycles after FILL_WAIT entry.
